// File: rtl/prog_delay_line.sv
// prog_delay_line
//   Runtime-programmable, multi-channel clocked delay line. Each channel delays
//   its WIDTH-bit input by 0..MAX_DELAY clk cycles. The delay is chosen per
//   channel at run time. A per-channel valid flag marks settled output data.
//   Used in the readout datapath to align hit/strobe streams between pixel groups.
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high; clears all state and blanks outputs
//   en          advance enable; low freezes write pointer, ring and fill
//   bypass      1 = dout follows din combinationally and all channels are valid
//   dly_sel     per-channel delay select, ch i at [i*DW +: DW]
//   din         per-channel data, ch i at [i*WIDTH +: WIDTH]
//   dout        delayed data, forced to 0 while the channel is not valid
//   dout_valid  per-channel: fill depth covers the programmed delay
//   cfg_err     sticky flag: a dly_sel above MAX_DELAY was sampled
module prog_delay_line #(
    parameter  int WIDTH     = 1,
    parameter  int CHANNELS  = 4,
    parameter  int MAX_DELAY = 15,
    localparam int DW        = $clog2(MAX_DELAY + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      bypass,
    input  logic [CHANNELS*DW-1:0]    dly_sel,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic [CHANNELS-1:0]       dout_valid,
    output logic                      cfg_err
);

    localparam logic [DW-1:0] MAXD = DW'(MAX_DELAY);
    localparam logic [DW-1:0] LAST = DW'(MAX_DELAY - 1);
    localparam logic [DW:0]   MAXE = (DW+1)'(MAX_DELAY);

    logic [WIDTH-1:0]    ring [CHANNELS][MAX_DELAY];
    logic [DW-1:0]       wptr;
    logic [DW-1:0]       dly_q   [CHANNELS];
    logic [DW-1:0]       fill    [CHANNELS];
    logic [DW-1:0]       dly_new [CHANNELS];
    logic [CHANNELS-1:0] dly_over;

    // Out-of-range selects are clamped to the deepest legal delay.
    always_comb begin
        dly_over = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            dly_over[i] = dly_sel[i*DW +: DW] > MAXD;
            dly_new[i]  = dly_over[i] ? MAXD : dly_sel[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr    <= '0;
            cfg_err <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                dly_q[i] <= '0;
                fill[i]  <= '0;
                for (int j = 0; j < MAX_DELAY; j++) begin
                    ring[i][j] <= '0;
                end
            end
        end else begin
            if (|dly_over) begin
                cfg_err <= 1'b1;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                // Config is sampled even while frozen.
                dly_q[i] <= dly_new[i];
                if (en) begin
                    ring[i][wptr] <= din[i*WIDTH +: WIDTH];
                end
                // A delay change restarts the fill count; this wins over the increment.
                if (dly_new[i] != dly_q[i]) begin
                    fill[i] <= '0;
                end else if (en && (fill[i] != MAXD)) begin
                    fill[i] <= fill[i] + 1'b1;
                end
            end
            if (en) begin
                wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            end
        end
    end

    // Read slot is (wptr - d) mod MAX_DELAY. For d == MAX_DELAY this is the
    // oldest entry, which is about to be overwritten on the coming edge.
    always_comb begin
        logic [DW:0]      sum;
        logic [DW-1:0]    idx;
        logic [WIDTH-1:0] data;
        logic             ok;
        dout       = '0;
        dout_valid = '0;
        sum        = '0;
        idx        = '0;
        data       = '0;
        ok         = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum = {1'b0, wptr} + MAXE - {1'b0, dly_q[i]};
            if (sum >= MAXE) begin
                sum = sum - MAXE;
            end
            idx  = sum[DW-1:0];
            ok   = fill[i] >= dly_q[i];
            data = (dly_q[i] == '0) ? din[i*WIDTH +: WIDTH] : ring[i][idx];
            if (reset) begin
                dout[i*WIDTH +: WIDTH] = '0;
                dout_valid[i]          = 1'b0;
            end else if (bypass) begin
                dout[i*WIDTH +: WIDTH] = din[i*WIDTH +: WIDTH];
                dout_valid[i]          = 1'b1;
            end else begin
                dout[i*WIDTH +: WIDTH] = ok ? data : '0;
                dout_valid[i]          = ok;
            end
        end
    end

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line. The main instance (MAX_DELAY=15) carries
// a counting stream: ch0=k, ch1=k+100, ch2=k+50, ch3=k+20. Here k counts
// enabled edges, so a channel with delay d should show the stream value k-d.
// A second instance (MAX_DELAY=10) exercises clamping and the sticky error flag.
module tb_prog_delay_line;

    logic        clk = 1'b0;
    logic        reset, en, bypass;
    logic [15:0] dly_sel;
    logic [31:0] din, dout;
    logic [3:0]  dout_valid;
    logic        cfg_err;

    logic        reset10, en10, bypass10;
    logic [15:0] dly_sel10;
    logic [31:0] din10, dout10;
    logic [3:0]  dout_valid10;
    logic        cfg_err10;

    int checks = 0;
    int passed = 0;
    int k = 0;
    int k10 = 0;

    always #5 clk = ~clk;

    prog_delay_line #(.WIDTH(8), .CHANNELS(4), .MAX_DELAY(15)) dut (
        .clk(clk), .reset(reset), .en(en), .bypass(bypass), .dly_sel(dly_sel),
        .din(din), .dout(dout), .dout_valid(dout_valid), .cfg_err(cfg_err)
    );

    prog_delay_line #(.WIDTH(8), .CHANNELS(4), .MAX_DELAY(10)) dut10 (
        .clk(clk), .reset(reset10), .en(en10), .bypass(bypass10), .dly_sel(dly_sel10),
        .din(din10), .dout(dout10), .dout_valid(dout_valid10), .cfg_err(cfg_err10)
    );

    task automatic drive_stream();
        din = {8'(k + 20), 8'(k + 50), 8'(k + 100), 8'(k)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One enabled edge, then present the next stream word and let it settle.
    task automatic advance();
        @(posedge clk);
        #1;
        k++;
        drive_stream();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; bypass = 1'b1;
        dly_sel = {4'd0, 4'd15, 4'd0, 4'd3};
        din = 32'hDEADBEEF;
        tick();
        tick();
        checks++; if (dout !== 32'h0) $display("FAIL reset_dout got %h want 0", dout); else passed++;
        checks++; if (dout_valid !== 4'h0) $display("FAIL reset_valid got %h want 0", dout_valid); else passed++;
        checks++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got %b want 0", cfg_err); else passed++;
    endtask

    task automatic test_zero_delay();
        reset = 1'b0; bypass = 1'b0;
        k = 0;
        drive_stream();
        #1;
        checks++; if (dout[15:8] !== 8'd100) $display("FAIL zero_dout got %0d want 100", dout[15:8]); else passed++;
        checks++; if (dout_valid[1] !== 1'b1) $display("FAIL zero_valid got %b want 1", dout_valid[1]); else passed++;
    endtask

    task automatic test_delay3();
        logic       ev;
        logic [7:0] ed;
        while (k < 20) begin
            advance();
            ev = (k >= 4);
            ed = ev ? 8'(k - 3) : 8'h0;
            checks++; if (dout_valid[0] !== ev) $display("FAIL d3_valid k=%0d got %b want %b", k, dout_valid[0], ev); else passed++;
            checks++; if (dout[7:0] !== ed) $display("FAIL d3_dout k=%0d got %0d want %0d", k, dout[7:0], ed); else passed++;
            checks++; if (dout[15:8] !== 8'(k + 100)) $display("FAIL d0_dout k=%0d got %0d want %0d", k, dout[15:8], 8'(k + 100)); else passed++;
        end
    endtask

    task automatic test_delay_max();
        logic       ev;
        logic [7:0] ed;
        while (k < 45) begin
            advance();
            ev = (k >= 16);
            ed = ev ? 8'(k + 35) : 8'h0;
            checks++; if (dout_valid[2] !== ev) $display("FAIL d15_valid k=%0d got %b want %b", k, dout_valid[2], ev); else passed++;
            checks++; if (dout[23:16] !== ed) $display("FAIL d15_dout k=%0d got %0d want %0d", k, dout[23:16], ed); else passed++;
            checks++; if (dout[7:0] !== 8'(k - 3)) $display("FAIL d3_run k=%0d got %0d want %0d", k, dout[7:0], 8'(k - 3)); else passed++;
        end
    endtask

    task automatic test_change();
        logic       ev;
        logic [7:0] ed;
        dly_sel[3:0] = 4'd7;
        repeat (10) begin
            advance();
            ev = (k >= 53);
            ed = ev ? 8'(k - 7) : 8'h0;
            checks++; if (dout_valid[0] !== ev) $display("FAIL chg_valid k=%0d got %b want %b", k, dout_valid[0], ev); else passed++;
            checks++; if (dout[7:0] !== ed) $display("FAIL chg_dout k=%0d got %0d want %0d", k, dout[7:0], ed); else passed++;
            checks++; if (dout[23:8] !== {8'(k + 35), 8'(k + 100)}) $display("FAIL chg_others k=%0d got %h want %h", k, dout[23:8], {8'(k + 35), 8'(k + 100)}); else passed++;
            checks++; if (dout_valid[2:1] !== 2'b11) $display("FAIL chg_others_valid got %b want 11", dout_valid[2:1]); else passed++;
        end
    endtask

    task automatic test_freeze();
        en = 1'b0;
        din = 32'hA5A5A5A5;
        repeat (5) begin
            tick();
            checks++; if (dout[7:0] !== 8'(k - 7)) $display("FAIL frz_ch0 got %0d want %0d", dout[7:0], 8'(k - 7)); else passed++;
            checks++; if (dout[23:16] !== 8'(k + 35)) $display("FAIL frz_ch2 got %0d want %0d", dout[23:16], 8'(k + 35)); else passed++;
            checks++; if (dout_valid !== 4'hF) $display("FAIL frz_valid got %h want F", dout_valid); else passed++;
        end
        en = 1'b1;
        drive_stream();
        #1;
        repeat (4) begin
            checks++; if (dout[7:0] !== 8'(k - 7)) $display("FAIL resume_ch0 k=%0d got %0d want %0d", k, dout[7:0], 8'(k - 7)); else passed++;
            checks++; if (dout[23:16] !== 8'(k + 35)) $display("FAIL resume_ch2 k=%0d got %0d want %0d", k, dout[23:16], 8'(k + 35)); else passed++;
            advance();
        end
        checks++; if (cfg_err !== 1'b0) $display("FAIL no_cfg_err got %b want 0", cfg_err); else passed++;
    endtask

    task automatic test_bypass();
        bypass = 1'b1;
        din = 32'h12345678;
        #1;
        checks++; if (dout !== 32'h12345678) $display("FAIL byp_dout got %h want 12345678", dout); else passed++;
        checks++; if (dout_valid !== 4'hF) $display("FAIL byp_valid got %h want F", dout_valid); else passed++;
        drive_stream();
        #1;
        repeat (3) begin
            advance();
            checks++; if (dout !== {8'(k + 20), 8'(k + 50), 8'(k + 100), 8'(k)}) $display("FAIL byp_stream got %h want %h", dout, {8'(k + 20), 8'(k + 50), 8'(k + 100), 8'(k)}); else passed++;
        end
        bypass = 1'b0;
        #1;
        checks++; if (dout[7:0] !== 8'(k - 7)) $display("FAIL unbyp_ch0 got %0d want %0d", dout[7:0], 8'(k - 7)); else passed++;
        checks++; if (dout[23:16] !== 8'(k + 35)) $display("FAIL unbyp_ch2 got %0d want %0d", dout[23:16], 8'(k + 35)); else passed++;
        checks++; if (dout_valid !== 4'hF) $display("FAIL unbyp_valid got %h want F", dout_valid); else passed++;
    endtask

    task automatic test_clamp();
        logic       ev;
        logic [7:0] ed;
        dly_sel10 = {4'hF, 12'h0};
        k10 = 0;
        din10 = {8'(k10), 24'h0};
        reset10 = 1'b0;
        #1;
        checks++; if (cfg_err10 !== 1'b0) $display("FAIL clamp_pre_err got %b want 0", cfg_err10); else passed++;
        repeat (12) begin
            @(posedge clk);
            #1;
            k10++;
            din10 = {8'(k10), 24'h0};
            #1;
            ev = (k10 >= 11);
            ed = ev ? 8'(k10 - 10) : 8'h0;
            checks++; if (cfg_err10 !== 1'b1) $display("FAIL clamp_err got %b want 1", cfg_err10); else passed++;
            checks++; if (dout_valid10[3] !== ev) $display("FAIL clamp_valid k=%0d got %b want %b", k10, dout_valid10[3], ev); else passed++;
            checks++; if (dout10[31:24] !== ed) $display("FAIL clamp_dout k=%0d got %0d want %0d", k10, dout10[31:24], ed); else passed++;
        end
        dly_sel10[15:12] = 4'd2;
        tick();
        checks++; if (cfg_err10 !== 1'b1) $display("FAIL sticky_err got %b want 1", cfg_err10); else passed++;
        bypass10 = 1'b1;
        reset10 = 1'b1;
        tick();
        checks++; if (dout10 !== 32'h0) $display("FAIL midrst_dout got %h want 0", dout10); else passed++;
        checks++; if (dout_valid10 !== 4'h0) $display("FAIL midrst_valid got %h want 0", dout_valid10); else passed++;
        checks++; if (cfg_err10 !== 1'b0) $display("FAIL midrst_err got %b want 0", cfg_err10); else passed++;
        reset10 = 1'b0;
        bypass10 = 1'b0;
        din10 = 32'h3C000000;
        #1;
        checks++; if (dout10[31:24] !== 8'h3C) $display("FAIL postrst_d0 got %h want 3c", dout10[31:24]); else passed++;
        checks++; if (dout_valid10 !== 4'hF) $display("FAIL postrst_valid got %h want F", dout_valid10); else passed++;
    endtask

    initial begin
        reset10 = 1'b1; en10 = 1'b1; bypass10 = 1'b0;
        dly_sel10 = '0; din10 = '0;
        test_reset();
        test_zero_delay();
        test_delay3();
        test_delay_max();
        test_change();
        test_freeze();
        test_bypass();
        test_clamp();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
